wb_unit: RTL and testbench
==========================

# wb_unit

Parametrised writeback stage that replaces the single-cycle writeback with one that handles variable-latency load data, sub-word load formatting (byte/half/word, plus double on 64-bit), squashes on pipeline flush and gates register-file writes. It sits between the memory stage and the register file. It provides a registered write port to the register file and a same-cycle forwarding path to the hazard/bypass logic.

## Interface
Parameters:
- XLEN, 32 — datapath width; legal values 32 or 64
- RA_W, 5 — register address width
- OFF_W, $clog2(XLEN/8) — byte-offset width (derived)

Ports:
- clk  in  1  — single clock; all state updates on rising edge
- rst_n  in  1  — reset, synchronous, active-low
- valid_i  in  1  — memory stage presents an instruction
- ready_o  out  1  — stage can accept; transfer when valid_i && ready_o
- sel_rd_i  in  RA_W  — destination register
- rd_we_i  in  1  — instruction writes rd
- mem_re_i  in  1  — instruction is a load
- load_type_i  in  3  — load funct3
- addr_off_i  in  OFF_W  — low bits of the load address
- alu_result_i  in  XLEN  — non-load result
- mem_rvalid_i  in  1  — load data valid this cycle
- mem_rdata_i  in  XLEN  — raw aligned memory word
- flush_i  in  1  — squash the in-flight instruction
- bypass_valid_o  out  1  — a commit with a register write occurs this cycle
- bypass_rd_o  out  RA_W  — rd of that commit
- data_bypass_o  out  XLEN  — formatted value of that commit
- we_o  out  1  — register-file write enable (registered)
- sel_rd_o  out  RA_W  — register-file write address (registered)
- data_o  out  XLEN  — register-file write data (registered)
- retire_o  out  1  — one-cycle pulse per committed instruction (registered)

## Operation
- FSM states:
  - IDLE: ready_o=1.
  - WAIT_MEM: ready_o=0; a load is accepted and its data is pending.
  - DRAIN: ready_o=0; a flushed load is still awaiting data that must be discarded.
- Transitions and commits:
  - IDLE, accept, non-load or mem_rvalid_i=1: commit immediately.
  - IDLE, accept, load with mem_rvalid_i=0: capture rd, rd_we, load_type and offset into holding registers; go to WAIT_MEM.
  - WAIT_MEM, mem_rvalid_i=1 and !flush_i: commit the held load; go to IDLE.
  - WAIT_MEM, flush_i=1 with mem_rvalid_i=0: go to DRAIN.
  - WAIT_MEM, flush_i=1 with mem_rvalid_i=1: discard the data; go to IDLE.
  - DRAIN, mem_rvalid_i=1: discard the data; go to IDLE. flush_i in DRAIN has no effect.
- flush_i in IDLE: valid_i is ignored that cycle; nothing is accepted or committed.
- mem_rvalid_i is ignored in IDLE unless an accepted load arrives in the same cycle.
- Commit write: register-file write happens only if rd_we && rd != 0. retire_o pulses for every commit, including commits that do not write.
- Load formatting (funct3):
  - 000 LB: sign-extend byte at offset*8.
  - 001 LH: sign-extend half at offset aligned down to 2 bytes.
  - 010 LW: word at offset aligned down to 4 bytes, sign-extended to XLEN.
  - 100 LBU / 101 LHU: zero-extend.
  - 110 LWU, 011 LD: XLEN=64 only.
  - Any other code, including 110/011 at XLEN=32, returns the raw mem_rdata_i.
- Offset bits below the access alignment are ignored. Misaligned accesses are not detected here.

## Timing
- Reset (rst_n=0 at clock edge):
  - state=IDLE.
  - we_o=0, sel_rd_o=0, data_o=0, retire_o=0.
  - Holding registers cleared.
- Reset mid-WAIT_MEM or DRAIN abandons the load; a later mem_rvalid_i is ignored.
- Commit in cycle N:
  - bypass_* asserted combinationally in cycle N.
  - we_o, sel_rd_o, data_o, retire_o valid in cycle N+1.
- we_o and retire_o are single-cycle pulses.
- sel_rd_o and data_o hold their last value when no commit occurs.
- ready_o depends only on state, never on valid_i.
- Load latency: 0 or more cycles after acceptance. Back-to-back non-loads sustain one commit per cycle.

## Structure
- Shared constants package gets:
  - load_type_e (funct3 enum)
  - wb_state_e {WB_IDLE, WB_WAIT_MEM, WB_DRAIN}
- Sub-module load_align: purely combinational (mem_rdata, load_type, offset → XLEN result), parametrised by XLEN. Instantiated once, with its inputs muxed between live and held fields.

## Test plan
- ALU op, rd=5, alu_result=0x1234, valid, rd_we → bypass_valid=1 same cycle; next cycle we_o=1, sel_rd_o=5, data_o=0x1234, retire_o=1.
- LB, offset=3, rdata=0x80FF_FFFF, rvalid two cycles after accept → ready_o=0 for two cycles; then data_o=0xFFFF_FF80; LBU on the same data gives 0x0000_0080.
- Write to rd=0 with rd_we=1 → we_o=0, retire_o=1.
- Load accepted, flush_i one cycle later, rvalid three cycles later → no we_o or retire_o; state returns to IDLE; ready_o=1 the cycle after rvalid.
- XLEN=64: LW, offset=4, rdata=0x8000_0000_0000_0000 → data_o=0xFFFF_FFFF_8000_0000; LD returns the raw word.
- rst_n=0 during WAIT_MEM, then rvalid → outputs stay 0; no spurious write.

Source files
------------

// File: rtl/wb_unit_pkg.sv
// Shared types for the writeback stage: load funct3 encodings and FSM states.
package wb_unit_pkg;

  typedef enum logic [2:0] {
    LT_LB  = 3'b000,
    LT_LH  = 3'b001,
    LT_LW  = 3'b010,
    LT_LD  = 3'b011,
    LT_LBU = 3'b100,
    LT_LHU = 3'b101,
    LT_LWU = 3'b110
  } load_type_e;

  typedef enum logic [1:0] {
    WB_IDLE,
    WB_WAIT_MEM,
    WB_DRAIN
  } wb_state_e;

endpackage

// File: rtl/wb_unit_if.sv
// Memory-stage request, register-file write and bypass signals of the writeback stage.
interface wb_unit_if #(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int OFF_W = $clog2(XLEN / 8)
);
  logic             valid_i;
  logic             ready_o;
  logic [RA_W-1:0]  sel_rd_i;
  logic             rd_we_i;
  logic             mem_re_i;
  logic [2:0]       load_type_i;
  logic [OFF_W-1:0] addr_off_i;
  logic [XLEN-1:0]  alu_result_i;
  logic             mem_rvalid_i;
  logic [XLEN-1:0]  mem_rdata_i;
  logic             flush_i;
  logic             bypass_valid_o;
  logic [RA_W-1:0]  bypass_rd_o;
  logic [XLEN-1:0]  data_bypass_o;
  logic             we_o;
  logic [RA_W-1:0]  sel_rd_o;
  logic [XLEN-1:0]  data_o;
  logic             retire_o;

  modport master (
    output valid_i, sel_rd_i, rd_we_i, mem_re_i, load_type_i, addr_off_i,
           alu_result_i, mem_rvalid_i, mem_rdata_i, flush_i,
    input  ready_o, bypass_valid_o, bypass_rd_o, data_bypass_o,
           we_o, sel_rd_o, data_o, retire_o
  );

  modport slave (
    input  valid_i, sel_rd_i, rd_we_i, mem_re_i, load_type_i, addr_off_i,
           alu_result_i, mem_rvalid_i, mem_rdata_i, flush_i,
    output ready_o, bypass_valid_o, bypass_rd_o, data_bypass_o,
           we_o, sel_rd_o, data_o, retire_o
  );
endinterface

// File: rtl/wb_unit_load_align.sv
// Combinational sub-word load formatter: selects byte/half/word at the offset and extends it.
module wb_unit_load_align
  import wb_unit_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int OFF_W = $clog2(XLEN / 8)
) (
  input  logic [XLEN-1:0]  rdata,
  input  logic [2:0]       load_type,
  input  logic [OFF_W-1:0] off,
  output logic [XLEN-1:0]  result
);

  // Offset bits below the access size are dropped by masking the bit-shift amount.
  localparam logic [OFF_W+2:0] HALF_LOW = (OFF_W + 3)'(15);
  localparam logic [OFF_W+2:0] WORD_LOW = (OFF_W + 3)'(31);

  logic        [OFF_W+2:0] sh_b, sh_h, sh_w;
  logic signed [7:0]       b_s;
  logic signed [15:0]      h_s;
  logic signed [31:0]      w_s;

  assign sh_b = {off, 3'b000};
  assign sh_h = sh_b & ~HALF_LOW;
  assign sh_w = sh_b & ~WORD_LOW;

  assign b_s = 8'(rdata >> sh_b);
  assign h_s = 16'(rdata >> sh_h);
  assign w_s = 32'(rdata >> sh_w);

  always_comb begin
    result = rdata;
    case (load_type_e'(load_type))
      LT_LB:  result = XLEN'(b_s);
      LT_LH:  result = XLEN'(h_s);
      LT_LW:  result = XLEN'(w_s);
      LT_LBU: result = XLEN'($unsigned(b_s));
      LT_LHU: result = XLEN'($unsigned(h_s));
      LT_LWU: if (XLEN == 64) result = XLEN'($unsigned(w_s));
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/wb_unit.sv
// Writeback stage: waits for variable-latency load data, formats it, squashes on flush,
// and drives a same-cycle bypass plus a registered register-file write port.
module wb_unit
  import wb_unit_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int OFF_W = $clog2(XLEN / 8)
) (
  input logic     clk,
  input logic     rst_n,
  wb_unit_if.slave bus
);

  wb_state_e        state, state_nxt;
  logic [RA_W-1:0]  hold_rd;
  logic             hold_we;
  logic [2:0]       hold_lt;
  logic [OFF_W-1:0] hold_off;

  logic             commit, capture, use_held, wr;
  logic [RA_W-1:0]  rd_sel;
  logic             we_sel, load_sel;
  logic [2:0]       lt_sel;
  logic [OFF_W-1:0] off_sel;
  logic [XLEN-1:0]  load_data, commit_data;

  logic             we_p1, retire_p1;
  logic [RA_W-1:0]  rd_p1;
  logic [XLEN-1:0]  data_p1;

  assign bus.ready_o = (state == WB_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= WB_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    capture   = 1'b0;
    unique case (state)
      WB_IDLE: begin
        // A flush in IDLE masks valid_i for that cycle.
        if (bus.valid_i && !bus.flush_i) begin
          if (bus.mem_re_i && !bus.mem_rvalid_i) begin
            capture   = 1'b1;
            state_nxt = WB_WAIT_MEM;
          end else begin
            commit = 1'b1;
          end
        end
      end
      WB_WAIT_MEM: begin
        if (bus.flush_i) begin
          state_nxt = bus.mem_rvalid_i ? WB_IDLE : WB_DRAIN;
        end else if (bus.mem_rvalid_i) begin
          commit    = 1'b1;
          state_nxt = WB_IDLE;
        end
      end
      WB_DRAIN: begin
        if (bus.mem_rvalid_i) state_nxt = WB_IDLE;
      end
      default: state_nxt = WB_IDLE;
    endcase
  end

  assign use_held = (state == WB_WAIT_MEM);
  assign rd_sel   = use_held ? hold_rd  : bus.sel_rd_i;
  assign we_sel   = use_held ? hold_we  : bus.rd_we_i;
  assign load_sel = use_held ? 1'b1     : bus.mem_re_i;
  assign lt_sel   = use_held ? hold_lt  : bus.load_type_i;
  assign off_sel  = use_held ? hold_off : bus.addr_off_i;

  wb_unit_load_align #(
    .XLEN  (XLEN),
    .OFF_W (OFF_W)
  ) u_align (
    .rdata     (bus.mem_rdata_i),
    .load_type (lt_sel),
    .off       (off_sel),
    .result    (load_data)
  );

  assign commit_data = load_sel ? load_data : bus.alu_result_i;
  assign wr          = commit && we_sel && (rd_sel != '0);

  assign bus.bypass_valid_o = wr;
  assign bus.bypass_rd_o    = rd_sel;
  assign bus.data_bypass_o  = commit_data;

  // Stage boundary: commit -> registered register-file port (p1)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_rd   <= '0;
      hold_we   <= 1'b0;
      hold_lt   <= '0;
      hold_off  <= '0;
      we_p1     <= 1'b0;
      retire_p1 <= 1'b0;
      rd_p1     <= '0;
      data_p1   <= '0;
    end else begin
      if (capture) begin
        hold_rd  <= bus.sel_rd_i;
        hold_we  <= bus.rd_we_i;
        hold_lt  <= bus.load_type_i;
        hold_off <= bus.addr_off_i;
      end
      we_p1     <= wr;
      retire_p1 <= commit;
      if (commit) begin
        rd_p1   <= rd_sel;
        data_p1 <= commit_data;
      end
    end
  end

  assign bus.we_o     = we_p1;
  assign bus.retire_o = retire_p1;
  assign bus.sel_rd_o = rd_p1;
  assign bus.data_o   = data_p1;

endmodule

// File: tb/tb_wb_unit.sv
// Bench for wb_unit: 32- and 64-bit instances share stimulus and are checked each cycle
// against a transaction-level model, after a set of directed scenarios with literal values.
module tb_wb_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  wb_unit_if #(.XLEN(32), .RA_W(5)) b32 ();
  wb_unit_if #(.XLEN(64), .RA_W(5)) b64 ();

  wb_unit #(.XLEN(32), .RA_W(5)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32));
  wb_unit #(.XLEN(64), .RA_W(5)) dut64 (.clk(clk), .rst_n(rst_n), .bus(b64));

  logic        v_valid, v_we, v_re, v_rvalid, v_flush;
  logic [4:0]  v_rd;
  logic [2:0]  v_lt, v_off;
  logic [63:0] v_alu, v_rdata;

  assign b32.valid_i      = v_valid;
  assign b32.sel_rd_i     = v_rd;
  assign b32.rd_we_i      = v_we;
  assign b32.mem_re_i     = v_re;
  assign b32.load_type_i  = v_lt;
  assign b32.addr_off_i   = v_off[1:0];
  assign b32.alu_result_i = v_alu[31:0];
  assign b32.mem_rvalid_i = v_rvalid;
  assign b32.mem_rdata_i  = v_rdata[31:0];
  assign b32.flush_i      = v_flush;

  assign b64.valid_i      = v_valid;
  assign b64.sel_rd_i     = v_rd;
  assign b64.rd_we_i      = v_we;
  assign b64.mem_re_i     = v_re;
  assign b64.load_type_i  = v_lt;
  assign b64.addr_off_i   = v_off;
  assign b64.alu_result_i = v_alu;
  assign b64.mem_rvalid_i = v_rvalid;
  assign b64.mem_rdata_i  = v_rdata;
  assign b64.flush_i      = v_flush;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference load formatting from the funct3 rules, using plain shifts and masks.
  function automatic logic [63:0] fmt(input int w, input logic [63:0] rd,
                                      input logic [2:0] lt, input int off);
    logic [63:0] mask, raw, b, h, wd, r;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    raw  = rd & mask;
    b    = (raw >> (8 * off)) & 64'hFF;
    h    = (raw >> (8 * (off & ~1))) & 64'hFFFF;
    wd   = (raw >> (8 * (off & ~3))) & 64'hFFFF_FFFF;
    case (lt)
      3'b000:  r = b[7]  ? (b  | ~64'hFF)        : b;
      3'b001:  r = h[15] ? (h  | ~64'hFFFF)      : h;
      3'b010:  r = wd[31] ? (wd | ~64'hFFFF_FFFF) : wd;
      3'b100:  r = b;
      3'b101:  r = h;
      3'b110:  r = (w == 64) ? wd : raw;
      default: r = raw;
    endcase
    return r & mask;
  endfunction

  // Model: an accepted load is either pending (to commit) or being discarded after a flush.
  bit          known = 0;
  bit          m_pending, m_discard;
  logic [4:0]  h_rd;
  logic        h_we;
  logic [2:0]  h_lt, h_off;
  logic        m_we, m_ret;
  logic [4:0]  m_rd;
  logic [63:0] m_d32, m_d64;

  always @(negedge clk) begin
    logic        c, cap, wv, ld, np, nd, wr;
    logic [4:0]  rd;
    logic [2:0]  lt, off;
    logic [63:0] e32, e64;
    c = 0; cap = 0; np = m_pending; nd = m_discard;
    rd = v_rd; wv = v_we; ld = v_re; lt = v_lt; off = v_off;
    if (known) begin
      chk("ready32", b32.ready_o, !(m_pending || m_discard));
      chk("ready64", b64.ready_o, !(m_pending || m_discard));
      chk("we32", b32.we_o, m_we);
      chk("we64", b64.we_o, m_we);
      chk("retire32", b32.retire_o, m_ret);
      chk("retire64", b64.retire_o, m_ret);
      chk("sel_rd32", b32.sel_rd_o, m_rd);
      chk("sel_rd64", b64.sel_rd_o, m_rd);
      chk("data32", b32.data_o, m_d32);
      chk("data64", b64.data_o, m_d64);
    end
    if (m_pending) begin
      rd = h_rd; wv = h_we; ld = 1'b1; lt = h_lt; off = h_off;
      if (v_flush) begin
        np = 0; nd = !v_rvalid;
      end else if (v_rvalid) begin
        c = 1; np = 0;
      end
    end else if (m_discard) begin
      if (v_rvalid) nd = 0;
    end else if (v_valid && !v_flush) begin
      if (v_re && !v_rvalid) begin
        cap = 1; np = 1;
      end else begin
        c = 1;
      end
    end
    wr  = c && wv && (rd != 0);
    e32 = ld ? fmt(32, v_rdata, lt, int'(off & 3'd3)) : (v_alu & 64'hFFFF_FFFF);
    e64 = ld ? fmt(64, v_rdata, lt, int'(off)) : v_alu;
    if (known) begin
      chk("byp_valid32", b32.bypass_valid_o, wr);
      chk("byp_valid64", b64.bypass_valid_o, wr);
      if (wr) begin
        chk("byp_rd32", b32.bypass_rd_o, rd);
        chk("byp_rd64", b64.bypass_rd_o, rd);
        chk("byp_data32", b32.data_bypass_o, e32);
        chk("byp_data64", b64.data_bypass_o, e64);
      end
    end
    if (!rst_n) begin
      known = 1; m_pending = 0; m_discard = 0;
      h_rd = 0; h_we = 0; h_lt = 0; h_off = 0;
      m_we = 0; m_ret = 0; m_rd = 0; m_d32 = 0; m_d64 = 0;
    end else if (known) begin
      m_pending = np; m_discard = nd;
      if (cap) begin
        h_rd = v_rd; h_we = v_we; h_lt = v_lt; h_off = v_off;
      end
      m_we = wr; m_ret = c;
      if (c) begin
        m_rd = rd; m_d32 = e32; m_d64 = e64;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    v_valid = 0; v_we = 0; v_re = 0; v_rvalid = 0; v_flush = 0;
    v_rd = 0; v_lt = 0; v_off = 0; v_alu = 0; v_rdata = 0;
  endtask

  task automatic issue(input logic re, input logic [4:0] rd, input logic [2:0] lt,
                       input logic [2:0] off, input logic [63:0] alu,
                       input logic rv, input logic [63:0] rdata);
    v_valid = 1; v_we = 1; v_re = re; v_rd = rd; v_lt = lt; v_off = off;
    v_alu = alu; v_rvalid = rv; v_rdata = rdata; v_flush = 0;
  endtask

  initial begin
    rst_n = 0;
    idle();
    repeat (3) cyc();
    // Reset state
    @(negedge clk);
    chk("rst_we", b32.we_o, 0);
    chk("rst_sel_rd", b32.sel_rd_o, 0);
    chk("rst_data", b32.data_o, 0);
    chk("rst_retire", b32.retire_o, 0);
    chk("rst_ready", b32.ready_o, 1);
    cyc();
    rst_n = 1;

    // ALU op to rd=5
    cyc(); issue(0, 5'd5, 3'd0, 3'd0, 64'h1234, 0, 64'h0);
    @(negedge clk);
    chk("alu_byp_valid", b32.bypass_valid_o, 1);
    chk("alu_byp_data", b32.data_bypass_o, 64'h1234);
    cyc(); idle();
    @(negedge clk);
    chk("alu_we", b32.we_o, 1);
    chk("alu_sel_rd", b32.sel_rd_o, 5);
    chk("alu_data", b32.data_o, 64'h1234);
    chk("alu_retire", b32.retire_o, 1);
    cyc();
    @(negedge clk);
    chk("alu_we_pulse", b32.we_o, 0);

    // LB offset 3, data two cycles after acceptance
    cyc(); issue(1, 5'd7, 3'b000, 3'd3, 64'h0, 0, 64'h0);
    cyc(); idle();
    @(negedge clk);
    chk("lb_ready_w1", b32.ready_o, 0);
    cyc(); idle(); v_rvalid = 1; v_rdata = 64'h80FF_FFFF;
    @(negedge clk);
    chk("lb_ready_w2", b32.ready_o, 0);
    chk("lb_byp_data", b32.data_bypass_o, 64'hFFFF_FF80);
    cyc(); idle();
    @(negedge clk);
    chk("lb_data", b32.data_o, 64'hFFFF_FF80);
    chk("lb_sel_rd", b32.sel_rd_o, 7);
    chk("lb_ready_back", b32.ready_o, 1);
    cyc(); issue(1, 5'd8, 3'b100, 3'd3, 64'h0, 1, 64'h80FF_FFFF);
    cyc(); idle();
    @(negedge clk);
    chk("lbu_data", b32.data_o, 64'h0000_0080);

    // Write to x0
    cyc(); issue(0, 5'd0, 3'd0, 3'd0, 64'hBEEF, 0, 64'h0);
    cyc(); idle();
    @(negedge clk);
    chk("x0_we", b32.we_o, 0);
    chk("x0_retire", b32.retire_o, 1);

    // Flush one cycle after acceptance, data three cycles after
    cyc(); issue(1, 5'd9, 3'b010, 3'd0, 64'h0, 0, 64'h0);
    cyc(); idle(); v_flush = 1;
    cyc(); idle();
    @(negedge clk);
    chk("drain_ready", b32.ready_o, 0);
    cyc(); idle(); v_rvalid = 1; v_rdata = 64'h1111_2222_3333_4444;
    cyc(); idle();
    @(negedge clk);
    chk("flush_ready", b32.ready_o, 1);
    chk("flush_retire", b32.retire_o, 0);
    chk("flush_we", b32.we_o, 0);

    // 64-bit LW at offset 4, then LD returning the raw word
    cyc(); issue(1, 5'd3, 3'b010, 3'd4, 64'h0, 1, 64'h8000_0000_0000_0000);
    cyc(); issue(1, 5'd4, 3'b011, 3'd0, 64'h0, 1, 64'h8000_0000_0000_0000);
    @(negedge clk);
    chk("lw64_data", b64.data_o, 64'hFFFF_FFFF_8000_0000);
    cyc(); idle();
    @(negedge clk);
    chk("ld64_data", b64.data_o, 64'h8000_0000_0000_0000);

    // Reset while waiting on load data
    cyc(); issue(1, 5'd11, 3'b010, 3'd0, 64'h0, 0, 64'h0);
    cyc(); idle(); rst_n = 0;
    cyc(); rst_n = 1; v_rvalid = 1; v_rdata = 64'hDEAD_BEEF_CAFE_F00D;
    @(negedge clk);
    chk("rstw_ready", b32.ready_o, 1);
    cyc(); idle();
    @(negedge clk);
    chk("rstw_we", b32.we_o, 0);
    chk("rstw_retire", b32.retire_o, 0);
    chk("rstw_data", b32.data_o, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cyc();
      rst_n    = ($urandom_range(0, 199) != 0);
      v_valid  = ($urandom_range(0, 9) < 7);
      v_re     = ($urandom_range(0, 1) == 1);
      v_rvalid = ($urandom_range(0, 9) < 4);
      v_flush  = ($urandom_range(0, 9) == 0);
      v_we     = ($urandom_range(0, 4) != 0);
      v_rd     = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      v_lt     = 3'($urandom);
      v_off    = 3'($urandom);
      v_alu    = {$urandom, $urandom};
      v_rdata  = {$urandom, $urandom};
    end
    cyc(); idle(); rst_n = 1;
    repeat (2) cyc();
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
